// File: rtl/spm_pipe_if.sv
// Operand/product bundle for spm_pipe: operand offer (in_valid/in_ready, a, b),
// serial product stream (p_bit, p_bit_valid), parallel product (out_valid/out_ready, p), sync clear.
// master drives operands, clear and out_ready; slave is the multiplier.
interface spm_pipe_if #(
    parameter int WIDTH = 32
);
    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 p_bit;
    logic                 p_bit_valid;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;

    modport master (
        output clear, in_valid, a, b, out_ready,
        input  in_ready, p_bit, p_bit_valid, out_valid, p
    );

    modport slave (
        input  clear, in_valid, a, b, out_ready,
        output in_ready, p_bit, p_bit_valid, out_valid, p
    );
endinterface

// File: rtl/spm_pipe.sv
// Serial-parallel carry-save multiplier: parallel a, b consumed LSB-first, product LSB-first on p_bit and in p.
// Latency: 2*WIDTH+1 cycles from the accepting cycle to out_valid; one product per 2*WIDTH+2 cycles.
// Backpressure: in_ready only in IDLE; p/out_valid held in DONE until out_ready. Ports: clk, rst (async, low), bus (slave).
module spm_pipe #(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 0
) (
    input  logic      clk,
    input  logic      rst,
    spm_pipe_if.slave bus
);
    localparam int            CW       = $clog2(2 * WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * WIDTH - 1);
    localparam logic          SGN      = (SIGNED != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   a_q, a_d;     // multiplicand
    logic [WIDTH-1:0]   b_q, b_d;     // multiplier shift register, LSB is the current bit
    logic [WIDTH-1:0]   s_q, s_d;     // per-cell sum flops
    logic [WIDTH-1:0]   c_q, c_d;     // per-cell carry flops
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic               y;
    logic               msb_in;
    logic [WIDTH-1:0]   pp;
    logic [WIDTH-1:0]   sum_in;
    logic [WIDTH-1:0]   fa_s;
    logic [WIDTH-1:0]   fa_c;

    // ---------------- carry-save array ----------------
    // The multiplier register shifts right; in signed mode it replicates its
    // MSB, so once the original bits are used up y keeps presenting b[WIDTH-1].
    assign y = b_q[0];

    // Signed mode: the MSB partial-product bit carries negative weight. It is
    // stored inverted ((1 - x) instead of -x); the surplus this adds over all
    // 2*WIDTH cycles is -2^(WIDTH-1) modulo 2^(2*WIDTH), which is cancelled by
    // injecting a single 1 into the MSB cell on the first RUN cycle.
    assign msb_in = SGN & (cnt_q == '0);
    assign pp     = (a_q & {WIDTH{y}}) ^ {SGN, {(WIDTH-1){1'b0}}};
    assign sum_in = {msb_in, s_q[WIDTH-1:1]};

    // Cell i: full adder of its partial-product bit, its own carry and the
    // sum of cell i+1. Cell 0's sum is the product bit for this cycle.
    assign fa_s = pp ^ c_q ^ sum_in;
    assign fa_c = (pp & c_q) | (pp & sum_in) | (c_q & sum_in);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.in_valid)        state_d = RUN;
                RUN:     if (cnt_q == CNT_LAST)   state_d = DONE;
                DONE:    if (bus.out_ready)       state_d = IDLE;
                default:                          state_d = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.in_ready    = (state_q == IDLE);
        bus.out_valid   = (state_q == DONE);
        bus.p_bit_valid = (state_q == RUN);
        bus.p_bit       = (state_q == RUN) & fa_s[0];
    end

    assign bus.p = p_q;

    // ---------------- datapath next state ----------------
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
        c_d   = c_q;
        cnt_d = cnt_q;
        p_d   = p_q;
        if (bus.clear) begin
            a_d   = '0;
            b_d   = '0;
            s_d   = '0;
            c_d   = '0;
            cnt_d = '0;
            p_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_d   = bus.a;
                        b_d   = bus.b;
                        s_d   = '0;
                        c_d   = '0;
                        cnt_d = '0;
                        p_d   = '0;
                    end
                end
                RUN: begin
                    s_d   = fa_s;
                    c_d   = fa_c;
                    b_d   = {SGN & b_q[WIDTH-1], b_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    // Product bits enter at the MSB so bit 0 ends at the LSB.
                    p_d   = {fa_s[0], p_q[2*WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            cnt_q <= '0;
            p_q   <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            cnt_q <= cnt_d;
            p_q   <= p_d;
        end
    end
endmodule

// File: doc/spm_pipe.md
SPM_PIPE -- requirements
Module: spm_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand width in bits, legal range 2..64.
REQ-002 The block SHALL have parameter SIGNED, default 0: 0 selects unsigned operands, 1 selects two's-complement operands.
REQ-003 The block SHALL have the following ports, one clock and one reset:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort; returns the block to IDLE.
- in_valid  input  1  operand pair is offered.
- in_ready  output  1  block will accept an operand pair.
- a  input  WIDTH  parallel multiplicand.
- b  input  WIDTH  multiplier, consumed LSB-first.
- p_bit  output  1  serial product bit, LSB first.
- p_bit_valid  output  1  p_bit is meaningful this cycle.
- out_valid  output  1  parallel product is available.
- out_ready  input  1  consumer accepts the product.
- p  output  2*WIDTH  parallel product.

Function
REQ-004 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-005 in_ready SHALL equal 1 only in IDLE, and out_valid SHALL equal 1 only in DONE.
REQ-006 In IDLE, when in_valid=1, the block SHALL capture a into the multiplicand register and b into the multiplier shift register, clear the carry/sum array and the product register, set cnt=0, and enter RUN on the next cycle.
REQ-007 In RUN, each cycle the block SHALL feed one multiplier bit y into a WIDTH-cell carry-save array:
- cell i combines a[i] AND y with its own sum/carry flops and the sum of cell i+1;
- y=b[cnt] for cnt<WIDTH;
- for cnt>=WIDTH, y=b[WIDTH-1] when SIGNED=1 and y=0 otherwise.
REQ-008 When SIGNED=1, the MSB cell SHALL apply the two's-complement weight of a[WIDTH-1], so that the result is correct for a=-2^(WIDTH-1).
REQ-009 In RUN, each cycle the array SHALL emit exactly one product bit on p_bit, with p_bit_valid=1, and that bit SHALL be shifted into p from the MSB end, so that p holds bit 0 at LSB after the final shift.
REQ-010 The counter and RUN duration SHALL behave as follows:
- cnt SHALL be ceil(log2(2*WIDTH+1)) bits wide and increment once per RUN cycle;
- RUN SHALL last exactly 2*WIDTH cycles;
- when cnt=2*WIDTH-1, the block SHALL enter DONE on the next edge.
REQ-011 In DONE, p SHALL equal a*b mod 2^(2*WIDTH), interpreted per SIGNED.
REQ-012 p and out_valid SHALL be held stable until a cycle with out_ready=1, after which the block SHALL return to IDLE.
REQ-013 Latency SHALL be exactly 2*WIDTH+1 cycles from the accepting edge to the first cycle with out_valid=1; throughput SHALL be one product per 2*WIDTH+2 cycles with out_ready tied high.
REQ-014 in_valid SHALL be ignored outside IDLE; the captured operands SHALL be unaffected by changes on a or b after acceptance.
REQ-015 p_bit_valid SHALL be 0 in IDLE and DONE, and p_bit SHALL be 0 whenever p_bit_valid=0.
REQ-016 clear=1 SHALL take priority over all other inputs in every state: on the next edge the FSM goes to IDLE and the array, cnt, p and all outputs reach their reset values.
REQ-017 If clear=1 and in_valid=1 occur in the same cycle in IDLE, the operands SHALL NOT be accepted.
REQ-018 If out_ready=1 arrives in the same cycle that DONE is first entered, the product SHALL be presented for that cycle and the block SHALL return to IDLE on the following edge.
REQ-019 The block SHALL contain no combinational path from in_valid, a or b to any output, and SHALL NOT combinationally depend out_valid on out_ready.

Reset
REQ-020 While rst=0, the block SHALL be in IDLE with the following values:
- in_ready=1;
- out_valid=0, p_bit=0, p_bit_valid=0;
- p=0, cnt=0;
- all array sum/carry flops 0.
REQ-021 Assertion of rst SHALL take effect immediately, without a clock edge, in any state, including mid-RUN, and SHALL discard the operation in progress.
REQ-022 After rst deasserts, the first operand SHALL be acceptable on the first rising edge.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- WIDTH=8, SIGNED=0, a=8'hFF, b=8'hFF, out_ready=1 -> out_valid rises 17 cycles after acceptance with p=16'hFE01, and the serial bits observed LSB-first match p.
- WIDTH=8, SIGNED=1, a=8'h80, b=8'h80 -> p=16'h4000; a=8'h80, b=8'h01 -> p=16'hFF80.
- Back-to-back operand pairs with out_ready low for 5 cycles in DONE -> p is stable and in_ready=0 throughout; the second pair is accepted only after the handshake.
- clear asserted at cnt=7 of RUN -> IDLE on the next edge, p=0; a fresh pair a=3, b=5 then yields p=15.
- rst pulsed low mid-RUN, asynchronous to clk -> outputs reach their reset values before the next edge; no out_valid appears for the aborted operation.
- Random constrained regression over WIDTH in {2, 8, 32} and both SIGNED values -> p matches a reference multiply for at least 10k products.
